regfile_reader: RTL and testbench

REGFILE_READER -- requirements
Module: regfile_reader

---
 rtl/regfile_reader.sv | 118 +++++++++++
 tb/tb_regfile_reader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_reader.sv
// Register-file dump engine: walks a contiguous, wrapping address range of a
// register file through its async read port and streams each register out as a valid/ready beat.
module regfile_reader #(
  parameter int AWL = 5,
  parameter int DWL = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [AWL-1:0] start_addr,
  input  logic [AWL:0]   count,
  output logic [AWL-1:0] ra,
  input  logic [DWL-1:0] rd,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [AWL-1:0] out_addr,
  output logic [DWL-1:0] out_data,
  output logic           out_last,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    FIN   = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [AWL-1:0] addr_q, addr_d;
  logic [AWL:0]   remaining_q, remaining_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;
  logic [AWL-1:0] out_addr_q, out_addr_d;
  logic [DWL-1:0] out_data_q, out_data_d;

  always_comb begin
    // NOTE: every next-state value defaults to its register first, so no path can infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            addr_d      = start_addr;
            remaining_d = count;
            state_d     = FETCH;
          end else begin
            state_d = FIN;
          end
        end
      end
      FETCH: begin
        // Capture the async read now; the beat then stays frozen however long SEND stalls.
        out_data_d  = rd;
        out_addr_d  = addr_q;
        out_last_d  = (remaining_q == (AWL+1)'(1));
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = FIN;
          end else begin
            addr_d      = addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            state_d     = FETCH;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

  assign ra        = addr_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);

endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader: a behavioural register file feeds the
// async read port, and each dump is checked beat by beat against its own address/data model.
module tb_regfile_reader;
  localparam int AWL   = 5;
  localparam int DWL   = 32;
  localparam int DEPTH = 1 << AWL;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [AWL-1:0] start_addr;
  logic [AWL:0]   count;
  logic [AWL-1:0] ra;
  logic [DWL-1:0] rd;
  logic           out_valid;
  logic           out_ready;
  logic [AWL-1:0] out_addr;
  logic [DWL-1:0] out_data;
  logic           out_last;
  logic           busy;
  logic           done;

  logic [DWL-1:0] regs [DEPTH];
  assign rd = regs[ra];

  regfile_reader #(.AWL(AWL), .DWL(DWL)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
    .ra(ra), .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_regs(input logic [DWL-1:0] key);
    for (int i = 0; i < DEPTH; i++) regs[i] = key ^ DWL'(i);
  endtask

  // done is observed k cycles after the start edge; with out_ready high
  // k = 2*count+1 (start cycle through done cycle spans 2*count+2 cycles).
  task automatic run_dump(input logic [AWL-1:0] sa, input int cnt, input int exp_beats,
                          input logic [AWL-1:0] exp_last_addr, input int exp_done,
                          input int stall_beat, input int stall_len, input bit poke);
    int beats = 0, done_cnt = 0, done_at = 0, stall_cnt = 0, last_cnt = 0;
    logic [AWL-1:0] last_addr = '0, snap_addr, ea;
    logic [DWL-1:0] snap_data;
    logic           snap_last;
    int bound = 2 * cnt + stall_len + 12;

    @(negedge clk);
    start = 1'b1; start_addr = sa; count = (AWL+1)'(cnt); out_ready = 1'b1;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      start = poke && (k == 2);
      if (poke && k == 2) begin
        start_addr = 5'd0;
        count      = 6'd1;
      end
      if (k == 1) check("busy_after_start", 64'(busy), 64'd1);

      if (stall_cnt > 0 && stall_cnt < stall_len) begin
        out_ready = 1'b0;
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_addr", 64'(out_addr), 64'(snap_addr));
        check("stall_data", 64'(out_data), 64'(snap_data));
        check("stall_last", 64'(out_last), 64'(snap_last));
        stall_cnt++;
      end else if (out_valid && beats == stall_beat && stall_cnt == 0 && stall_len > 0) begin
        out_ready = 1'b0;
        snap_addr = out_addr;
        snap_data = out_data;
        snap_last = out_last;
        stall_cnt = 1;
      end else begin
        out_ready = 1'b1;
      end

      if (out_valid && out_ready) begin
        ea = sa + AWL'(beats);
        check("beat_addr", 64'(out_addr), 64'(ea));
        check("beat_data", 64'(out_data), 64'(regs[ea]));
        check("beat_last", 64'(out_last), 64'(beats == cnt - 1));
        if (out_last) begin
          last_cnt++;
          last_addr = out_addr;
        end
        beats++;
      end

      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = k;
          check("busy_at_done", 64'(busy), 64'd1);
        end
      end
      if (done_at != 0 && k == done_at + 1) check("busy_after_done", 64'(busy), 64'd0);
      if (done_at != 0 && k == done_at + 3) break;
    end
    out_ready = 1'b1;
    check("beat_count", 64'(beats), 64'(exp_beats));
    check("done_cycle", 64'(done_at), 64'(exp_done));
    check("done_pulses", 64'(done_cnt), 64'd1);
    if (exp_beats > 0) begin
      check("last_count", 64'(last_cnt), 64'd1);
      check("last_addr", 64'(last_addr), 64'(exp_last_addr));
    end
  endtask

  typedef struct {
    logic [AWL-1:0] sa;
    int             cnt;
    logic [DWL-1:0] key;
    int             exp_beats;
    logic [AWL-1:0] exp_last_addr;
    int             exp_done;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{sa: 5'd0,  cnt: 32, key: 32'h0000_0000, exp_beats: 32, exp_last_addr: 5'd31, exp_done: 65};
    vecs[1] = '{sa: 5'd30, cnt: 4,  key: 32'h0000_0000, exp_beats: 4,  exp_last_addr: 5'd1,  exp_done: 9};
    vecs[2] = '{sa: 5'd5,  cnt: 1,  key: 32'hA5C3_0F00, exp_beats: 1,  exp_last_addr: 5'd5,  exp_done: 3};
    vecs[3] = '{sa: 5'd31, cnt: 2,  key: 32'h1234_5600, exp_beats: 2,  exp_last_addr: 5'd0,  exp_done: 5};
    vecs[4] = '{sa: 5'd7,  cnt: 0,  key: 32'h1234_5600, exp_beats: 0,  exp_last_addr: 5'd0,  exp_done: 1};
    vecs[5] = '{sa: 5'd17, cnt: 5,  key: 32'hDEAD_BE00, exp_beats: 5,  exp_last_addr: 5'd21, exp_done: 11};

    rst = 1'b1; start = 1'b0; start_addr = '0; count = '0; out_ready = 1'b1;
    load_regs(32'h0);
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_ra", 64'(ra), 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      load_regs(vecs[i].key);
      run_dump(vecs[i].sa, vecs[i].cnt, vecs[i].exp_beats, vecs[i].exp_last_addr,
               vecs[i].exp_done, -1, 0, 1'b0);
    end

    // Backpressure: second beat held off for 5 cycles.
    load_regs(32'h5A00_0000);
    run_dump(5'd10, 3, 3, 5'd12, 12, 1, 5, 1'b0);

    // start pulsed mid-dump must be ignored.
    run_dump(5'd12, 4, 4, 5'd15, 9, -1, 0, 1'b1);

    // Reset during the second beat of a count=8 dump, with start also high.
    begin
      int seen = 0;
      bit hit = 1'b0;
      @(negedge clk);
      start = 1'b1; start_addr = 5'd3; count = 6'd8; out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        start = 1'b0;
        if (out_valid && seen == 1) begin
          rst = 1'b1; start = 1'b1; start_addr = 5'd9; count = 6'd2;
          hit = 1'b1;
          break;
        end
        if (out_valid && out_ready) seen++;
      end
      check("mid_rst_reached", 64'(hit), 64'd1);
      @(negedge clk);
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_done", 64'(done), 64'd0);
      check("mid_rst_last", 64'(out_last), 64'd0);
      check("mid_rst_out_addr", 64'(out_addr), 64'd0);
      check("mid_rst_out_data", 64'(out_data), 64'd0);
      check("mid_rst_ra", 64'(ra), 64'd0);
      rst = 1'b0; start = 1'b0;
      run_dump(5'd20, 3, 3, 5'd22, 7, -1, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
